// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and data-length helpers.
// The receiver path imports this package as well.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} tx_state_t;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  function automatic logic [3:0] data_len_to_bits(input logic [1:0] len);
    return 4'd5 + {2'b00, len};
  endfunction

endpackage

// File: rtl/transmitter_shift_register.sv
// Holds the frame's data bits, shifts them out LSB-first, and keeps the parity
// bit computed over the active data bits at load time.
module transmitter_shift_register
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        data_len,
  input  logic              parity_odd,
  output logic              serial_bit,
  output logic              parity_bit
);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] mask;
  logic              parity_q;

  // Bits beyond the configured length must not contribute to parity.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = (i < int'(data_len_to_bits(data_len)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      shift_q  <= data;
      parity_q <= (^(data & mask)) ^ parity_odd;
    end else if (shift) begin
      shift_q  <= shift_q >> 1;
    end
  end

  assign serial_bit = shift_q[0];
  assign parity_bit = parity_q;

endmodule

// File: rtl/transmitter_controller.sv
// UART transmit engine: accepts a byte per handshake and serialises it as
// start, 5-8 data bits, optional parity, and 1-2 stop bits on baud ticks.
module transmitter_controller
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en_i,
  input  logic              cts_ni,
  input  logic              baud_tick_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [1:0]        data_len_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              stop2_i,
  output logic              baud_restart_o,
  output logic              tx_o,
  output logic              tx_busy_o,
  output logic              tx_done_o
);

  tx_state_t  state, state_next;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic [3:0] len_q;
  logic       parity_en_q;
  logic       stop2_q;
  logic       tx_q;
  logic       accept;
  logic       last_bit;
  logic       serial_bit;
  logic       parity_bit;

  assign tx_ready_o     = (state == IDLE) && tx_en_i && !cts_ni;
  assign accept         = tx_valid_i && tx_ready_o;
  assign baud_restart_o = accept;
  assign last_bit       = ({1'b0, bit_cnt} == (len_q - 4'd1));

  transmitter_shift_register #(.DATA_W(DATA_W)) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .shift      ((state == DATA) && baud_tick_i),
    .data       (tx_data_i),
    .data_len   (data_len_i),
    .parity_odd (parity_odd_i),
    .serial_bit (serial_bit),
    .parity_bit (parity_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = START;
      START:   if (baud_tick_i) state_next = DATA;
      DATA:    if (baud_tick_i && last_bit) state_next = parity_en_q ? PARITY : STOP;
      PARITY:  if (baud_tick_i) state_next = STOP;
      STOP:    if (baud_tick_i && !(stop2_q && !stop_cnt)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame configuration is captured at accept so mid-frame changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      len_q       <= '0;
      parity_en_q <= 1'b0;
      stop2_q     <= 1'b0;
    end else begin
      if (accept) begin
        len_q       <= data_len_to_bits(data_len_i);
        parity_en_q <= parity_en_i;
        stop2_q     <= stop2_i;
        stop_cnt    <= 1'b0;
        bit_cnt     <= '0;
      end
      if (state == START && baud_tick_i) bit_cnt <= '0;
      if (state == DATA && baud_tick_i)  bit_cnt <= bit_cnt + 3'd1;
      if (state == STOP && baud_tick_i)  stop_cnt <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q <= 1'b1;
    end else begin
      unique case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= serial_bit;
        PARITY:  tx_q <= parity_bit;
        default: tx_q <= 1'b1;
      endcase
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign tx_done_o = (state == DONE);

endmodule

// File: tb/tb_transmitter_controller.sv
// Self-checking bench for transmitter_controller: directed frames plus random
// frames compared cycle by cycle against a frame-level bit-list model.
module tb_transmitter_controller;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en_i;
  logic       cts_ni;
  logic       baud_tick_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [1:0] data_len_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       stop2_i;
  logic       baud_restart_o;
  logic       tx_o;
  logic       tx_busy_o;
  logic       tx_done_o;

  int checks = 0;
  int errors = 0;
  int baud_period = 16;
  int baud_cnt = 0;
  int gap;
  logic exp_bits[$];

  transmitter_controller #(.DATA_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .tx_en_i        (tx_en_i),
    .cts_ni         (cts_ni),
    .baud_tick_i    (baud_tick_i),
    .tx_data_i      (tx_data_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .data_len_i     (data_len_i),
    .parity_en_i    (parity_en_i),
    .parity_odd_i   (parity_odd_i),
    .stop2_i        (stop2_i),
    .baud_restart_o (baud_restart_o),
    .tx_o           (tx_o),
    .tx_busy_o      (tx_busy_o),
    .tx_done_o      (tx_done_o)
  );

  always #5 clk = ~clk;

  // Free-running baud generator that resynchronises on baud_restart_o.
  always @(posedge clk) begin
    if (baud_restart_o)                 baud_cnt <= 0;
    else if (baud_cnt >= baud_period-1) baud_cnt <= 0;
    else                                baud_cnt <= baud_cnt + 1;
  end
  assign baud_tick_i = (baud_cnt == baud_period - 1);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per bit period.
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] len,
                                      input logic pe, input logic po, input logic s2);
    int   n;
    logic par;
    n   = 5 + int'(len);
    par = po;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      par = par ^ d[i];
    end
    if (pe) exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endfunction

  // Called just after a negedge; returns at the negedge of the DONE cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] len, input logic pe,
                               input logic po, input logic s2, input bit hold,
                               input logic [7:0] next_d, output int waits);
    int   nb;
    int   last;
    logic exp_tx;
    waits = 0;
    build_frame(d, len, pe, po, s2);
    nb   = exp_bits.size();
    last = nb * baud_period + 1;
    tx_data_i = d; data_len_i = len; parity_en_i = pe; parity_odd_i = po; stop2_i = s2;
    tx_en_i = 1'b1; cts_ni = 1'b0; tx_valid_i = 1'b1;
    #1;
    while (!tx_ready_o && waits < 4) begin
      checkOutput("idle_line", tx_o, 1);
      @(negedge clk); #1;
      waits++;
    end
    checkOutput("accept_ready", tx_ready_o, 1);
    if (!tx_ready_o) return;
    checkOutput("baud_restart", baud_restart_o, 1);
    @(posedge clk); #1;
    if (hold) begin
      tx_data_i = next_d;
    end else begin
      tx_data_i    = 8'($urandom);
      data_len_i   = 2'($urandom_range(3));
      parity_en_i  = 1'($urandom_range(1));
      parity_odd_i = 1'($urandom_range(1));
      stop2_i      = 1'($urandom_range(1));
      tx_en_i      = 1'($urandom_range(1));
      cts_ni       = 1'b1;
      tx_valid_i   = 1'($urandom_range(1));
    end
    for (int m = 1; m <= last; m++) begin
      @(negedge clk);
      exp_tx = (m >= 2) ? exp_bits[(m-2)/baud_period] : 1'b1;
      checkOutput((m >= 2) ? $sformatf("tx_bit%0d", (m-2)/baud_period) : "tx_pre", tx_o, exp_tx);
      checkOutput("tx_busy", tx_busy_o, (m < last) ? 1 : 0);
      checkOutput("tx_done", tx_done_o, (m == last) ? 1 : 0);
      checkOutput("tx_ready_busy", tx_ready_o, 0);
      checkOutput("no_restart", baud_restart_o, 0);
    end
  endtask

  initial begin
    reset = 1'b1; tx_en_i = 1'b1; cts_ni = 1'b0; tx_valid_i = 1'b0;
    tx_data_i = '0; data_len_i = LEN_8; parity_en_i = 0; parity_odd_i = 0; stop2_i = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx_o, 1);
    checkOutput("rst_busy", tx_busy_o, 0);
    checkOutput("rst_done", tx_done_o, 0);
    checkOutput("rst_restart", baud_restart_o, 0);
    checkOutput("rst_ready", tx_ready_o, 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5, LEN_8, 0, 0, 0, 0, 8'h00, gap);
    $display("[TB] 8E1 / 8O1 0x55");
    applyStimulus(8'h55, LEN_8, 1, 0, 0, 0, 8'h00, gap);
    applyStimulus(8'h55, LEN_8, 1, 1, 0, 0, 8'h00, gap);
    $display("[TB] 5N2 / 5E2 0xFF");
    applyStimulus(8'hFF, LEN_5, 0, 0, 1, 0, 8'h00, gap);
    applyStimulus(8'hFF, LEN_5, 1, 0, 1, 0, 8'h00, gap);

    $display("[TB] cts blocking");
    repeat (2) @(negedge clk);
    tx_en_i = 1'b1; cts_ni = 1'b1; tx_valid_i = 1'b1; tx_data_i = 8'h3C;
    repeat (20) begin
      @(negedge clk);
      checkOutput("cts_ready", tx_ready_o, 0);
      checkOutput("cts_line", tx_o, 1);
      checkOutput("cts_restart", baud_restart_o, 0);
    end
    applyStimulus(8'h3C, LEN_7, 1, 1, 0, 0, 8'h00, gap);
    checkOutput("cts_accept_gap", gap, 0);

    $display("[TB] back-to-back 0x01 then 0x80");
    repeat (3) @(negedge clk);
    applyStimulus(8'h01, LEN_8, 0, 0, 0, 1, 8'h80, gap);
    applyStimulus(8'h80, LEN_8, 0, 0, 0, 0, 8'h00, gap);
    checkOutput("b2b_gap", gap, 1);

    $display("[TB] reset mid-frame");
    tx_data_i = 8'hC3; data_len_i = LEN_8; parity_en_i = 0; parity_odd_i = 0; stop2_i = 0;
    tx_en_i = 1'b1; cts_ni = 1'b0; tx_valid_i = 1'b1;
    #1;
    gap = 0;
    while (!tx_ready_o && gap < 4) begin
      @(negedge clk); #1;
      gap++;
    end
    checkOutput("rstmid_ready", tx_ready_o, 1);
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    repeat (2 + 4*16 + 8) @(negedge clk);
    checkOutput("rstmid_busy_before", tx_busy_o, 1);
    checkOutput("rstmid_bit3", tx_o, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstmid_tx", tx_o, 1);
    checkOutput("rstmid_busy", tx_busy_o, 0);
    checkOutput("rstmid_done", tx_done_o, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(8'h96, LEN_6, 1, 0, 1, 0, 8'h00, gap);

    $display("[TB] random frames");
    repeat (12) begin
      baud_period = int'($urandom_range(20, 4));
      applyStimulus(8'($urandom), 2'($urandom_range(3)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 0, 8'h00, gap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
